// File: rtl/mos_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mos_sweep_pkg
// Description : Shared constants, register map and FSM encoding for the
//               6502 decoder sweep controller.
//               Optional feature macro: SWEEP_IRQ_EN (completion interrupt).
// Revision    : 1.0 - initial release
// ============================================================================
package mos_sweep_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_SIG    = 4'h8;
  localparam logic [3:0] OFF_RANGE  = 4'hC;

  // CTRL bit positions
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_SETTLE_LSB = 8;

  // STATUS bit positions
  localparam int STATUS_BUSY_BIT   = 0;
  localparam int STATUS_DONE_BIT   = 1;
  localparam int STATUS_OPCODE_LSB = 8;
  localparam int STATUS_ZCNT_LSB   = 16;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_CAPTURE = 2'd3
  } sweep_state_e;

  // Signature polynomial and seed
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;

  // Reset defaults
  localparam logic [7:0] RANGE_FIRST_RST = 8'h00;
  localparam logic [7:0] RANGE_LAST_RST  = 8'hFF;
  localparam logic [3:0] SETTLE_RST      = 4'd2;

  // One signature step: shift/reduce the running CRC, then xor in the
  // 66-bit decoder result folded down to 32 bits.
  function automatic logic [31:0] sig_step(input logic [31:0] sig,
                                           input logic [65:0] res);
    logic [31:0] fold;
    fold = res[31:0] ^ res[63:32] ^ {30'b0, res[65:64]};
    return {sig[30:0], 1'b0} ^ (sig[31] ? CRC_POLY : 32'h0) ^ fold;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mos_decoder_sweep_ctrl_sig.sv
`default_nettype none
// ============================================================================
// Module      : mos_sweep_sig
// Description : Running CRC signature and all-zero result counter for the
//               decoder sweep. clear has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module mos_sweep_sig
  import mos_sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [65:0] result,
  output logic [31:0] sig_o,
  output logic [8:0]  zero_count_o
);

  logic [31:0] sig_q, sig_d;
  logic [8:0]  zero_count_q, zero_count_d;

  // Next signature / counter: restart on clear, fold one result on enable
  always_comb begin
    sig_d        = sig_q;
    zero_count_d = zero_count_q;
    if (clear) begin
      sig_d        = SIG_SEED;
      zero_count_d = 9'd0;
    end else if (enable) begin
      sig_d = sig_step(sig_q, result);
      if (result == 66'd0) zero_count_d = zero_count_q + 9'd1;
    end
  end

  // Signature state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q        <= SIG_SEED;
      zero_count_q <= 9'd0;
    end else begin
      sig_q        <= sig_d;
      zero_count_q <= zero_count_d;
    end
  end

  assign sig_o        = sig_q;
  assign zero_count_o = zero_count_q;

endmodule
`default_nettype wire

// File: rtl/mos_decoder_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mos_decoder_sweep_ctrl
// Description : Wishbone-controlled sequencer that sweeps the 6502 decoder
//               over an opcode range and signs the results.
//               Optional feature macro: SWEEP_IRQ_EN (adds irq_o and
//               CTRL.IRQ_ENABLE).
// Revision    : 1.0 - initial release
// ============================================================================
module mos_decoder_sweep_ctrl
  import mos_sweep_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0010
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [65:0] decoder_result_i,
  output logic [7:0]  decoder_instruction_o
`ifdef SWEEP_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  sweep_state_e state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  instr_q, instr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  settle_q, settle_d;
  logic [7:0]  first_q, first_d;
  logic [7:0]  last_q, last_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
`ifdef SWEEP_IRQ_EN
  logic        irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
`endif

  logic [31:0] adr_off;
  logic        adr_hit, req, ctrl_wr, range_wr, start_cmd, abort_cmd, busy;
  logic        sig_clear, sig_en;
  logic [31:0] sig;
  logic [8:0]  zero_count;
  logic [31:0] rd_data;
  logic        unused_ok;

  // Byte selects are ignored; only some write-data bits carry fields
  assign unused_ok = ^{wbs_sel_i, wbs_dat_i[31:12], wbs_dat_i[7:2]};

  assign adr_off   = wbs_adr_i - BASE_ADDR;
  assign adr_hit   = (adr_off[31:4] == 28'd0) && (adr_off[1:0] == 2'd0);
  // Suppressing a request while ack is high forces the mandatory idle cycle
  assign req       = wbs_stb_i & wbs_cyc_i & adr_hit & ~ack_q;
  assign ctrl_wr   = req & wbs_we_i & (adr_off[3:0] == OFF_CTRL);
  assign range_wr  = req & wbs_we_i & (adr_off[3:0] == OFF_RANGE);
  assign abort_cmd = ctrl_wr & wbs_dat_i[CTRL_ABORT_BIT];
  assign start_cmd = ctrl_wr & wbs_dat_i[CTRL_START_BIT] & ~wbs_dat_i[CTRL_ABORT_BIT];
  assign busy      = (state_q != ST_IDLE);

  // Register read multiplexer
  always_comb begin
    rd_data = 32'd0;
    case (adr_off[3:0])
      OFF_CTRL: begin
        rd_data[CTRL_SETTLE_LSB +: 4] = settle_q;
`ifdef SWEEP_IRQ_EN
        rd_data[CTRL_IRQ_EN_BIT]      = irq_en_q;
`endif
      end
      OFF_STATUS: begin
        rd_data[STATUS_BUSY_BIT]        = busy;
        rd_data[STATUS_DONE_BIT]        = done_q;
        rd_data[STATUS_OPCODE_LSB +: 8] = opcode_q;
        rd_data[STATUS_ZCNT_LSB +: 9]   = zero_count;
      end
      OFF_SIG:   rd_data = sig;
      OFF_RANGE: rd_data = {16'd0, last_q, first_q};
      default:   rd_data = 32'd0;
    endcase
  end

  // Next-state logic for the sequencer, config registers and bus slave
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    first_d   = first_q;
    last_d    = last_q;
    done_d    = done_q;
    sig_clear = 1'b0;
    sig_en    = 1'b0;
    ack_d     = req;
    dat_d     = (req & ~wbs_we_i) ? rd_data : 32'd0;
`ifdef SWEEP_IRQ_EN
    irq_en_d  = ctrl_wr ? wbs_dat_i[CTRL_IRQ_EN_BIT] : irq_en_q;
    irq_d     = 1'b0;
`endif

    // Configuration is frozen while a sweep is running
    if (ctrl_wr && !busy)  settle_d = wbs_dat_i[CTRL_SETTLE_LSB +: 4];
    if (range_wr && !busy) begin
      first_d = wbs_dat_i[7:0];
      last_d  = wbs_dat_i[15:8];
    end

    case (state_q)
      ST_IDLE: begin
        if (start_cmd) begin
          opcode_d  = first_q;
          sig_clear = 1'b1;
          done_d    = 1'b0;
          state_d   = ST_APPLY;
        end
      end
      ST_APPLY: begin
        instr_d = opcode_q;
        cnt_d   = settle_q;
        state_d = (settle_q == 4'd0) ? ST_CAPTURE : ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        sig_en = 1'b1;
        if (opcode_q == last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
`ifdef SWEEP_IRQ_EN
          irq_d   = irq_en_q;
`endif
        end else begin
          opcode_d = opcode_q + 8'd1;
          state_d  = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any progress this cycle, including a final capture
    if (abort_cmd && busy) begin
      state_d  = ST_IDLE;
      sig_en   = 1'b0;
      done_d   = done_q;
      opcode_d = opcode_q;
`ifdef SWEEP_IRQ_EN
      irq_d    = 1'b0;
`endif
    end
  end

  // Sequencer FSM, config and bus registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= ST_IDLE;
      opcode_q <= 8'd0;
      instr_q  <= 8'd0;
      cnt_q    <= 4'd0;
      settle_q <= SETTLE_RST;
      first_q  <= RANGE_FIRST_RST;
      last_q   <= RANGE_LAST_RST;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
`ifdef SWEEP_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      first_q  <= first_d;
      last_q   <= last_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
`ifdef SWEEP_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

  mos_sweep_sig u_sig (
    .clk          (wb_clk_i),
    .rst_n        (wb_rst_ni),
    .clear        (sig_clear),
    .enable       (sig_en),
    .result       (decoder_result_i),
    .sig_o        (sig),
    .zero_count_o (zero_count)
  );

  assign wbs_ack_o             = ack_q;
  assign wbs_dat_o             = dat_q;
  assign decoder_instruction_o = instr_q;
`ifdef SWEEP_IRQ_EN
  assign irq_o                 = irq_q;
`endif

endmodule
`default_nettype wire

// File: doc/mos_decoder_sweep_ctrl.md
# mos_decoder_sweep_ctrl

Wishbone-controlled sequencer that drives the 6502 instruction decoder through a programmable opcode range. For each opcode it waits a settle interval, then folds the decoder's 66-bit result into a 32-bit CRC signature and counts all-zero (undecoded) results. It sits beside the decoder register bank in the user project area and replaces manual per-opcode Wishbone pokes with one start command, so a whole decoder can be checked in silicon by reading back a single signature.

## Interface
- BASE_ADDR, 32'h3000_0010: byte address of register 0; the block decodes BASE_ADDR+0x0 to +0xC.
- wb_clk_i  in  1  the single clock.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write-enable.
- wbs_sel_i  in  4  byte selects; ignored, every write is a full word.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data; 0 whenever the block is not acknowledging.
- decoder_result_i  in  66  decoder output, sampled in CAPTURE.
- decoder_instruction_o  out  8  opcode presented to the decoder.
- irq_o  out  1  only when SWEEP_IRQ_EN is defined.

## Operation
- Registers (offset from BASE_ADDR):
  - 0x0 CTRL
    - Write: bit0 START, bit1 ABORT, bits[11:8] SETTLE.
    - Read: SETTLE in bits[11:8]; all other bits read 0.
  - 0x4 STATUS, read-only: bit0 BUSY, bit1 DONE (sticky), bits[15:8] current opcode, bits[24:16] zero_count.
  - 0x8 SIG, read-only: 32-bit signature.
  - 0xC RANGE, read/write: bits[7:0] FIRST, bits[15:8] LAST.
- SETTLE and RANGE writes are ignored while BUSY; reads are always allowed.
- START when idle:
  - opcode ← FIRST.
  - SIG ← 32'hFFFF_FFFF, zero_count ← 0, DONE ← 0.
  - Enter APPLY.
- START while BUSY is ignored. ABORT wins if START and ABORT are written together.
- FSM states:
  - IDLE: wait for START.
  - APPLY (1 cycle): decoder_instruction_o ← opcode; load settle counter with SETTLE.
  - SETTLE: counts down to 0; skipped entirely when SETTLE = 0.
  - CAPTURE (1 cycle):
    - fold = res[31:0] ^ res[63:32] ^ {30'b0, res[65:64]}.
    - SIG ← {SIG[30:0],1'b0} ^ (SIG[31] ? 32'h04C1_1DB7 : 0) ^ fold.
    - If res == 0, zero_count++.
    - If opcode == LAST: go to IDLE and set DONE. Otherwise opcode ← opcode+1 (mod 256) and go to APPLY.
- Range wrap: if FIRST > LAST the sweep wraps 0xFF→0x00. Opcode count = ((LAST−FIRST) mod 256) + 1, always 1 to 256.
- zero_count is 9 bits, range 0 to 256, and cannot overflow.
- ABORT while BUSY: go to IDLE on the next edge. DONE stays 0; SIG and zero_count keep their partial values.
- decoder_instruction_o holds its last value in IDLE.
- Accesses outside the four offsets receive no ack.

## Timing
- Wishbone: ack is asserted the cycle after stb & cyc & address match, for exactly 1 cycle, then low for at least 1 cycle. Read data is valid with the ack.
- START accepted at edge T → BUSY = 1 and state APPLY at T+1.
- Each opcode takes SETTLE + 2 cycles. BUSY falls (DONE rises) N·(SETTLE+2) cycles after T+1.
- decoder_result_i must be stable SETTLE+1 cycles after decoder_instruction_o changes.
- Reset values:
  - wbs_ack_o = 0, wbs_dat_o = 0.
  - decoder_instruction_o = 0.
  - SIG = 32'hFFFF_FFFF, zero_count = 0.
  - FIRST = 0x00, LAST = 0xFF, SETTLE = 2.
  - BUSY = 0, DONE = 0, irq_o = 0, state IDLE.
- Reset mid-sweep takes effect immediately and asynchronously; no capture completes.

## Configuration
- SWEEP_IRQ_EN defined:
  - irq_o pulses high for 1 cycle on the edge where DONE rises.
  - CTRL bit2 IRQ_ENABLE (read/write, reset 0) gates the pulse.
- SWEEP_IRQ_EN undefined: no irq_o port; CTRL bit2 reads 0 and writes to it are ignored.

## Structure
- Package mos_sweep_pkg holds:
  - register offsets 0x0/0x4/0x8/0xC;
  - CTRL/STATUS bit positions;
  - FSM state enum (IDLE, APPLY, SETTLE, CAPTURE);
  - CRC_POLY = 32'h04C1_1DB7, SIG_SEED = 32'hFFFF_FFFF;
  - reset defaults for RANGE and SETTLE.
- Sub-module mos_sweep_sig contains the fold and CRC step plus the zero detect, with inputs clear, enable and result[65:0]. The top level keeps the FSM and the Wishbone slave.

## Test plan
- Reset, then read all four registers → CTRL=0x200, STATUS=0, SIG=0xFFFF_FFFF, RANGE=0x0000FF00; no ack for BASE+0x10.
- RANGE=0xA9A9, SETTLE=0, result tied to 0, START → BUSY for 2 cycles; then SIG=0xFB3E_E249, zero_count=1, DONE=1, opcode 0xA9.
- Default range, SETTLE=2, result = {58'b0, opcode} → 1024 cycles BUSY, zero_count=1 (opcode 0x00 only), SIG matches the golden model.
- RANGE FIRST=0xFE LAST=0x01 → decoder_instruction_o sequence FE, FF, 00, 01; DONE after 4·(SETTLE+2) cycles.
- ABORT at opcode 0x40 of a full sweep → IDLE next cycle, DONE=0, STATUS opcode=0x40; a second START mid-sweep and a RANGE write while BUSY are both ignored.
- Drop wb_rst_ni mid-sweep → all outputs return to reset values immediately; a new START then runs the sweep to normal completion.
